// File: rtl/clb_cfg_array.sv
// clb_cfg_array: NUM_LUT-slice configurable logic block whose LUT tables and slice
// options are loaded over a serial scan chain. Define CLB_PARITY_EN to add an even-parity bit.
module clb_cfg_array #(
  parameter int LUT_K   = 4,
  parameter int NUM_LUT = 2
) (
  input  logic                       K,
  input  logic                       RN,
  input  logic                       CFG_EN,
  input  logic                       CFG_DIN,
  output logic                       CFG_DOUT,
  output logic                       CFG_DONE,
  output logic                       CFG_ERR,
  input  logic [NUM_LUT*LUT_K-1:0]   IN,
  input  logic                       CE,
  input  logic                       SR,
  output logic [NUM_LUT-1:0]         OUT,
  output logic [NUM_LUT-1:0]         Q
);

  localparam int TBL_W = 2**LUT_K;
  localparam int FLD_W = TBL_W + 3;
`ifdef CLB_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int CFG_W = NUM_LUT * FLD_W + PAR_W;
  localparam int CNT_W = $clog2(CFG_W + 2);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CFG_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [CFG_W-1:0]     cfg_r;
  logic [CNT_W-1:0]     cnt_r;
  logic                 cfg_ok_s;
  logic                 run_s;
  logic                 err_s;
  logic [NUM_LUT-1:0]   q_r;
  logic [NUM_LUT-1:0]   q_nxt_s;
  logic [NUM_LUT-1:0]   f_s;
  logic [NUM_LUT-1:0]   osel_s;
  logic [NUM_LUT-1:0]   fbsel_s;
  logic [NUM_LUT-1:0]   ceuse_s;
  logic [NUM_LUT-1:0]   out_s;

`ifdef CLB_PARITY_EN
  // Total XOR of the register; an even-parity image XORs to zero.
  function automatic logic cfg_parity_odd(input logic [CFG_W-1:0] v);
    return ^v;
  endfunction

  assign cfg_ok_s = (cnt_r == CNT_FULL) && !cfg_parity_odd(cfg_r);
`else
  assign cfg_ok_s = (cnt_r == CNT_FULL);
`endif

  // Configuration scan register: shifts MSB-ward whenever the enable is high, in any state.
  always_ff @(posedge K or negedge RN) begin
    if (!RN) begin
      cfg_r <= {CFG_W{1'b0}};
    end else if (CFG_EN) begin
      cfg_r <= {cfg_r[CFG_W-2:0], CFG_DIN};
    end
  end

  // Shifted-bit counter: restarts at one on the first bit of a load, saturates past full length.
  always_ff @(posedge K or negedge RN) begin
    if (!RN) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (CFG_EN) begin
      if (state_r != ST_LOAD) begin
        cnt_r <= CNT_ONE;
      end else if (cnt_r != CNT_SAT) begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  // Configuration FSM state register.
  always_ff @(posedge K or negedge RN) begin
    if (!RN) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: any enable restarts a load; the load is judged when the enable drops.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (CFG_EN) state_nxt_s = ST_LOAD;
        else        state_nxt_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (CFG_EN)        state_nxt_s = ST_LOAD;
        else if (cfg_ok_s) state_nxt_s = ST_RUN;
        else               state_nxt_s = ST_ERR;
      end
      ST_RUN: begin
        if (CFG_EN) state_nxt_s = ST_LOAD;
        else        state_nxt_s = ST_RUN;
      end
      ST_ERR: begin
        if (CFG_EN) state_nxt_s = ST_LOAD;
        else        state_nxt_s = ST_ERR;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State decode for status and output gating.
  always_comb begin
    run_s = 1'b0;
    err_s = 1'b0;
    case (state_r)
      ST_IDLE: begin run_s = 1'b0; err_s = 1'b0; end
      ST_LOAD: begin run_s = 1'b0; err_s = 1'b0; end
      ST_RUN:  begin run_s = 1'b1; err_s = 1'b0; end
      ST_ERR:  begin run_s = 1'b0; err_s = 1'b1; end
      default: begin run_s = 1'b0; err_s = 1'b0; end
    endcase
  end

  for (genvar g = 0; g < NUM_LUT; g++) begin : g_slice
    logic [FLD_W-1:0] fld_s;
    logic [TBL_W-1:0] tbl_s;
    logic [LUT_K-1:0] idx_s;

    assign fld_s      = cfg_r[PAR_W + g*FLD_W +: FLD_W];
    assign tbl_s      = fld_s[TBL_W-1:0];
    assign osel_s[g]  = fld_s[TBL_W];
    assign fbsel_s[g] = fld_s[TBL_W+1];
    assign ceuse_s[g] = fld_s[TBL_W+2];

    // LUT address: input 0 may be replaced by the slice's own flop for feedback.
    always_comb begin
      idx_s = IN[g*LUT_K +: LUT_K];
      if (fbsel_s[g]) begin
        idx_s[0] = q_r[g];
      end else begin
        idx_s[0] = IN[g*LUT_K];
      end
    end

    assign f_s[g] = tbl_s[idx_s];
  end

  // Slice flop next value: cleared outside RUN and on reload; SR dominates CE.
  always_comb begin
    q_nxt_s = q_r;
    if (!run_s || CFG_EN) begin
      q_nxt_s = {NUM_LUT{1'b0}};
    end else if (SR) begin
      q_nxt_s = {NUM_LUT{1'b0}};
    end else begin
      for (int i = 0; i < NUM_LUT; i++) begin
        if (!ceuse_s[i] || CE) begin
          q_nxt_s[i] = f_s[i];
        end else begin
          q_nxt_s[i] = q_r[i];
        end
      end
    end
  end

  // Slice flops.
  always_ff @(posedge K or negedge RN) begin
    if (!RN) begin
      q_r <= {NUM_LUT{1'b0}};
    end else begin
      q_r <= q_nxt_s;
    end
  end

  // Slice output mux, held low until a valid configuration is running.
  always_comb begin
    out_s = {NUM_LUT{1'b0}};
    if (run_s) begin
      out_s = (osel_s & q_r) | (~osel_s & f_s);
    end else begin
      out_s = {NUM_LUT{1'b0}};
    end
  end

  assign OUT      = out_s;
  assign Q        = q_r;
  assign CFG_DOUT = cfg_r[CFG_W-1];
  assign CFG_DONE = run_s;
  assign CFG_ERR  = err_s;

endmodule

// File: tb/tb_clb_cfg_array.sv
// Directed scoreboard bench for clb_cfg_array with LUT_K=4, NUM_LUT=2.
// Honours CLB_PARITY_EN when the design is built with it.
module tb_clb_cfg_array;

`ifdef CLB_PARITY_EN
  localparam int CW = 39;
`else
  localparam int CW = 38;
`endif

  localparam logic [37:0] F_COMB = {3'b000, 16'h6996, 3'b000, 16'h8000};
  localparam logic [37:0] F_REG  = {3'b100, 16'h0000, 3'b101, 16'h8000};
  localparam logic [37:0] F_FB   = {3'b000, 16'h0000, 3'b011, 16'h5555};

  logic       K;
  logic       RN;
  logic       CFG_EN;
  logic       CFG_DIN;
  logic       CFG_DOUT;
  logic       CFG_DONE;
  logic       CFG_ERR;
  logic [7:0] IN;
  logic       CE;
  logic       SR;
  logic [1:0] OUT;
  logic [1:0] Q;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp;
  int          n_err;
  logic [63:0] sh;

  clb_cfg_array #(.LUT_K(4), .NUM_LUT(2)) dut (
    .K(K), .RN(RN), .CFG_EN(CFG_EN), .CFG_DIN(CFG_DIN), .CFG_DOUT(CFG_DOUT),
    .CFG_DONE(CFG_DONE), .CFG_ERR(CFG_ERR), .IN(IN), .CE(CE), .SR(SR),
    .OUT(OUT), .Q(Q)
  );

  initial K = 1'b0;
  always #5 K = ~K;

  function automatic logic [63:0] word(input logic [37:0] f);
`ifdef CLB_PARITY_EN
    return {25'd0, f, ^f};
`else
    return {26'd0, f};
`endif
  endfunction

  // Expected status byte; CFG_DOUT comes from the bench's own shift-register model.
  function automatic logic [7:0] st(input logic d, input logic e, input logic [1:0] q, input logic [1:0] o);
    return {1'b0, d, e, sh[CW-1], q, o};
  endfunction

  task automatic push(input string tag, input logic [7:0] v);
    exp_t x;
    x.tag = tag;
    x.val = v;
    sb.push_back(x);
  endtask

  task automatic cmp();
    logic [7:0] obs;
    exp_t       x;
    obs = {1'b0, CFG_DONE, CFG_ERR, CFG_DOUT, Q, OUT};
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty: observed %b expected none", obs);
    end else begin
      x = sb.pop_front();
      assert (obs === x.val) else begin
        n_err++;
        $error("FAIL %s: observed {done,err,dout,q,out}=%b expected %b", x.tag, obs, x.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge K);
    #1;
  endtask

  // Shift n bits of w MSB-first, then drop the enable for the judging edge.
  task automatic shift(input logic [63:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      CFG_EN  = 1'b1;
      CFG_DIN = w[i];
      @(posedge K);
      sh = {sh[62:0], w[i]};
      #1;
      if (i == n - 1) begin
        push("load_busy", st(1'b0, 1'b0, 2'b00, 2'b00));
        cmp();
      end
    end
    CFG_EN  = 1'b0;
    CFG_DIN = 1'b0;
    tick();
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    sh      = 64'd0;
    RN      = 1'b0;
    CFG_EN  = 1'b0;
    CFG_DIN = 1'b0;
    IN      = 8'hFF;
    CE      = 1'b0;
    SR      = 1'b0;

    #12;
    push("reset", st(1'b0, 1'b0, 2'b00, 2'b00)); cmp();
    RN = 1'b1;
    tick();
    push("idle", st(1'b0, 1'b0, 2'b00, 2'b00)); cmp();

    // Combinational slices: slice1 4-input parity, slice0 4-input AND.
    IN = 8'h1F;
    shift(word(F_COMB), CW);
    push("comb_1f", st(1'b1, 1'b0, 2'b00, 2'b11)); cmp();
    IN = 8'h0E; #1;
    push("comb_0e", st(1'b1, 1'b0, 2'b00, 2'b00)); cmp();
    IN = 8'h80; #1;
    push("comb_80", st(1'b1, 1'b0, 2'b00, 2'b10)); cmp();
    IN = 8'hFF; #1;
    push("comb_ff", st(1'b1, 1'b0, 2'b00, 2'b01)); cmp();
    tick();
    push("comb_q_ff", st(1'b1, 1'b0, 2'b01, 2'b01)); cmp();
    IN = 8'h80;
    tick();
    push("comb_q_80", st(1'b1, 1'b0, 2'b10, 2'b10)); cmp();

    // Registered slice0 with clock enable and synchronous clear.
    IN = 8'h0F; CE = 1'b0; SR = 1'b0;
    shift(word(F_REG), CW);
    push("reg_entry", st(1'b1, 1'b0, 2'b00, 2'b00)); cmp();
    tick();
    push("reg_ce0", st(1'b1, 1'b0, 2'b00, 2'b00)); cmp();
    CE = 1'b1;
    tick();
    push("reg_ce1", st(1'b1, 1'b0, 2'b01, 2'b01)); cmp();
    SR = 1'b1;
    tick();
    push("reg_sr", st(1'b1, 1'b0, 2'b00, 2'b00)); cmp();
    SR = 1'b0; CE = 1'b0;
    tick();
    push("reg_sr_off_ce0", st(1'b1, 1'b0, 2'b00, 2'b00)); cmp();
    CE = 1'b1;
    tick();
    push("reg_recapture", st(1'b1, 1'b0, 2'b01, 2'b01)); cmp();
    CE = 1'b0; IN = 8'h00;
    tick();
    push("reg_hold", st(1'b1, 1'b0, 2'b01, 2'b01)); cmp();

    // Feedback toggle: F = ~Q[0].
    IN = 8'h00;
    shift(word(F_FB), CW);
    push("fb_entry", st(1'b1, 1'b0, 2'b00, 2'b00)); cmp();
    tick(); push("fb_t1", st(1'b1, 1'b0, 2'b01, 2'b01)); cmp();
    tick(); push("fb_t2", st(1'b1, 1'b0, 2'b00, 2'b00)); cmp();
    tick(); push("fb_t3", st(1'b1, 1'b0, 2'b01, 2'b01)); cmp();
    tick(); push("fb_t4", st(1'b1, 1'b0, 2'b00, 2'b00)); cmp();

    // Length errors.
    IN = 8'hFF;
    shift(word(F_COMB), CW - 1);
    push("short_load", st(1'b0, 1'b1, 2'b00, 2'b00)); cmp();
    shift(word(F_COMB), CW + 1);
    push("long_load", st(1'b0, 1'b1, 2'b00, 2'b00)); cmp();
    shift(word(F_COMB), CW + 5);
    push("sat_load", st(1'b0, 1'b1, 2'b00, 2'b00)); cmp();
    shift(word(F_COMB), CW);
    push("reload", st(1'b1, 1'b0, 2'b00, 2'b01)); cmp();
    shift(word(F_COMB), 1);
    push("one_bit_load", st(1'b0, 1'b1, 2'b00, 2'b00)); cmp();

    // Reset mid-load returns to IDLE, not ERR.
    for (int i = 0; i < 10; i++) begin
      CFG_EN  = 1'b1;
      CFG_DIN = i[0];
      @(posedge K);
      sh = {sh[62:0], i[0]};
      #1;
    end
    RN = 1'b0;
    sh = 64'd0;
    #1;
    push("rst_mid_load", st(1'b0, 1'b0, 2'b00, 2'b00)); cmp();
    CFG_EN = 1'b0;
    #2;
    RN = 1'b1;
    tick();
    push("idle_after_rst", st(1'b0, 1'b0, 2'b00, 2'b00)); cmp();
    shift(word(F_COMB), CW);
    push("load_after_rst", st(1'b1, 1'b0, 2'b00, 2'b01)); cmp();

`ifdef CLB_PARITY_EN
    shift(word(F_COMB) ^ 64'h20, CW);
    push("parity_bad", st(1'b0, 1'b1, 2'b00, 2'b00)); cmp();
    shift(word(F_COMB), CW);
    push("parity_good", st(1'b1, 1'b0, 2'b00, 2'b01)); cmp();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
